counter_mod: RTL



---
 rtl/counter_mod.sv | 114 +++++++++++
 1 files changed

// File: rtl/counter_mod.sv
// counter_mod: parametrised modulo counter with up/down direction, parallel
// load with clamp, synchronous clear, terminal-count and wrap/zero flags.
// Optional feature macro: COUNTER_MOD_SAT_EN (defined = saturate at the
// terminal value instead of wrapping; wrap output stays 0).
module counter_mod #(
  parameter int unsigned     WIDTH = 8,
  parameter longint unsigned MOD   = 64'd1 << WIDTH,
  parameter longint unsigned INIT  = 0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclrn,
  input  logic             ena,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             zero
);

  // Elaboration-time legality of the configuration.
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("counter_mod: WIDTH must be in 2..32");
  end
  if (MOD < 2 || MOD > (64'd1 << WIDTH)) begin : g_bad_mod
    $error("counter_mod: MOD must be in 2..2**WIDTH");
  end
  if (INIT >= MOD) begin : g_bad_init
    $error("counter_mod: INIT must be below MOD");
  end

  localparam longint unsigned  MAX_L     = MOD - 1;
  localparam logic [WIDTH:0]   MOD_X     = MOD[WIDTH:0];
  localparam logic [WIDTH:0]   ONE_X     = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_Q     = MAX_L[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INIT_Q    = INIT[WIDTH-1:0];
  localparam logic             INIT_ZERO = (INIT == 0);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             zero_q, zero_d;

  // Next values are formed one bit wider so MOD == 2**WIDTH cannot overflow.
  logic [WIDTH:0] q_ext, inc_x, dec_x, d_ext;
  logic           at_top, at_bot;

  // Terminal detection and combinational terminal-count output.
  always_comb begin
    q_ext  = {1'b0, q_q};
    d_ext  = {1'b0, d};
    inc_x  = q_ext + ONE_X;
    dec_x  = q_ext - ONE_X;
    at_top = (inc_x == MOD_X);
    at_bot = dec_x[WIDTH];
    tc     = ena & (up ? at_top : at_bot);
  end

  // Next-state selection: sync clear > load > count > hold.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (!sclrn) begin
      q_d = INIT_Q;
    end else if (load) begin
      q_d = (d_ext < MOD_X) ? d : MAX_Q;
    end else if (ena) begin
      if (up) begin
        if (at_top) begin
`ifdef COUNTER_MOD_SAT_EN
          q_d    = q_q;
`else
          q_d    = '0;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = inc_x[WIDTH-1:0];
        end
      end else begin
        if (at_bot) begin
`ifdef COUNTER_MOD_SAT_EN
          q_d    = q_q;
`else
          q_d    = MAX_Q;
          wrap_d = 1'b1;
`endif
        end else begin
          q_d = dec_x[WIDTH-1:0];
        end
      end
    end
    // zero is registered from the next value so it always matches q.
    zero_d = (q_d == '0);
  end

  // State registers with asynchronous active-high clear.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_q    <= INIT_Q;
      wrap_q <= 1'b0;
      zero_q <= INIT_ZERO;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      zero_q <= zero_d;
    end
  end

  assign q    = q_q;
  assign wrap = wrap_q;
  assign zero = zero_q;

endmodule
